map_sel_ctrl: RTL
=================

# map_sel_ctrl

Sequencer that owns the world-map select used by the rojobot and VGA read paths. It replaces a direct switch-driven map mux with a controlled change. A new map request must be stable for a qualification time. The select then changes only at a vertical-sync boundary, so no torn frame is displayed. Optionally, the rojobot is held in reset briefly so it restarts on the new map. It runs in the 75 MHz video/rojobot domain, between the debounced switches and the three world-map BRAM outputs.

## Interface
Parameters:
- STABLE_CYCLES, 75000: cycles a new request must be held before commit (1 ms at 75 MHz); min 1
- BOT_RST_CYCLES, 16: cycles bot_rst is held high after commit; min 1
- VS_ACTIVE, 1'b0: active level of vert_sync

Ports:
- clk  in  1  single clock (75 MHz video/rojobot clock)
- reset_n  in  1  asynchronous, active-low reset
- map_req  in  2  debounced switches {lr, loop}
- vert_sync  in  1  vertical sync from the display timing generator, same clock
- map_sel  out  2  registered map select to the BRAM output mux
- bot_rst  out  1  active-high reset request, ORed into the rojobot reset
- switching  out  1  high whenever state != IDLE
- map_chg  out  1  one-cycle pulse when a change sequence completes

## Operation
- Request decode, combinational, with priority: map_req[1] → MAP_LR (2); else map_req[0] → MAP_LOOP (1); else MAP_PART1 (0). The decoded value is called dreq.
- FSM states: IDLE, QUALIFY, WAIT_VS, BOT_RST.
- IDLE:
  - If dreq != map_sel: latch cand <= dreq, cnt <= 0, go to QUALIFY.
- QUALIFY:
  - If dreq != cand: go to IDLE. The next cycle re-evaluates, so a fresh qualification restarts from cnt=0.
  - Else if cnt == STABLE_CYCLES-1: go to WAIT_VS.
  - Else cnt++.
- WAIT_VS:
  - Wait for vs_edge, the inactive→active transition of vert_sync.
  - On vs_edge: map_sel <= cand, bot_rst <= 1, cnt <= 0, go to BOT_RST.
  - Request changes while in WAIT_VS are ignored; cand is committed, and the new request is handled from IDLE afterwards.
- BOT_RST:
  - When cnt == BOT_RST_CYCLES-1: bot_rst <= 0, map_chg <= 1 for one cycle, go to IDLE.
  - Else cnt++.
- cand returning to the current map_sel before commit is covered by the QUALIFY abort; no commit occurs.
- Counter width: $clog2(max(STABLE_CYCLES, BOT_RST_CYCLES)+1). There is no wrap; the counter saturates by construction.

## Timing
- Reset values: map_sel=0 (PART1), bot_rst=0, switching=0, map_chg=0, state=IDLE, cnt=0, cand=0, vs_q=inactive.
- Reset is asynchronous and may occur mid-sequence. All registers return to reset values immediately; bot_rst drops with reset. On release, a request != PART1 starts a full sequence.
- vs_q is a one-cycle registered copy of vert_sync. vs_edge = (vert_sync==VS_ACTIVE) && (vs_q!=VS_ACTIVE).
- vs_edge is only acted on in WAIT_VS. An edge in the same cycle as the QUALIFY→WAIT_VS transition is not used; the next frame's edge is.
- Latency:
  - dreq change at cycle t → QUALIFY at t+1.
  - WAIT_VS entered at t+1+STABLE_CYCLES.
  - map_sel changes on the clock after the first vs_edge seen in WAIT_VS.
  - bot_rst is high for exactly BOT_RST_CYCLES cycles, starting the same cycle map_sel changes.
  - map_chg pulses the cycle bot_rst falls.
- switching rises one cycle after the request is detected. It falls in the same cycle map_chg asserts.

## Configuration
- MAP_SEL_BOT_RESET_EN
  - Defined: BOT_RST state and bot_rst behaviour as above.
  - Undefined: BOT_RST state is removed; bot_rst is tied 0. On vs_edge in WAIT_VS, map_sel <= cand and map_chg pulses on the following cycle; state goes to IDLE. BOT_RST_CYCLES is unused.

## Structure
- Shared header map_sel_const.vh:
  - map codes MAP_PART1=2'd0, MAP_LOOP=2'd1, MAP_LR=2'd2
  - FSM state encodings
  - Both are included by map_sel_ctrl and by any bench or top that decodes map_sel.
- One sub-module, vs_edge_det: the registered vert_sync plus edge output, parameterised by VS_ACTIVE. Everything else stays in map_sel_ctrl.

## Test plan
Use STABLE_CYCLES=4, BOT_RST_CYCLES=3, VS_ACTIVE=0.

- Reset, then map_req=2'b00 steady → map_sel=0, bot_rst=0, switching=0, no map_chg for 100 cycles.
- map_req=2'b01 held, vert_sync low pulse 20 cycles later → map_sel=1 on the clock after the falling edge; bot_rst high 3 cycles; map_chg one pulse as bot_rst falls.
- map_req=2'b11 → commits MAP_LR (2), confirming the priority decode.
- map_req=2'b01 for 2 cycles then back to 2'b00 → QUALIFY aborts; map_sel stays 0; no bot_rst, no map_chg.
- map_req changes 2'b01→2'b10 during WAIT_VS → map_sel=1 at the first vs_edge. A second full sequence then commits map_sel=2 at a later vs_edge.
- reset_n asserted low while bot_rst=1 → bot_rst and all outputs 0 immediately. After release with map_req=2'b01, a full sequence repeats.
- Build with MAP_SEL_BOT_RESET_EN undefined → bot_rst never asserts; map_chg pulses one cycle after the map_sel change.

Source files
------------

// File: rtl/map_sel_ctrl_pkg.sv
// Shared map codes, FSM state encodings and request decode for map_sel_ctrl and anything decoding map_sel.
package map_sel_ctrl_pkg;

  localparam logic [1:0] MAP_PART1 = 2'd0;
  localparam logic [1:0] MAP_LOOP  = 2'd1;
  localparam logic [1:0] MAP_LR    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_WAIT_VS = 2'd2,
    ST_BOT_RST = 2'd3
  } state_t;

  // Switch priority: lr wins over loop, neither selects part 1.
  function automatic logic [1:0] decode_req(input logic [1:0] req);
    if (req[1]) return MAP_LR;
    if (req[0]) return MAP_LOOP;
    return MAP_PART1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/map_sel_ctrl_vs_edge_det.sv
// vs_edge_det: registers vert_sync and flags the inactive-to-active transition, same cycle as the active level appears.
module vs_edge_det #(
  parameter logic VS_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vert_sync,
  output logic vs_edge
);

  logic vs_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vs_q <= ~VS_ACTIVE;
    else          vs_q <= vert_sync;
  end

  assign vs_edge = (vert_sync == VS_ACTIVE) && (vs_q != VS_ACTIVE);

endmodule

// File: rtl/map_sel_ctrl.sv
// map_sel_ctrl: qualifies a map request for STABLE_CYCLES, then commits it on the next vsync edge (no torn frames).
// MAP_SEL_BOT_RESET_EN adds a BOT_RST_CYCLES rojobot reset hold after commit; undefined ties bot_rst low.
module map_sel_ctrl
  import map_sel_ctrl_pkg::*;
#(
  parameter int   STABLE_CYCLES  = 75000,
  parameter int   BOT_RST_CYCLES = 16,
  parameter logic VS_ACTIVE      = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] map_req,
  input  logic       vert_sync,
  output logic [1:0] map_sel,
  output logic       bot_rst,
  output logic       switching,
  output logic       map_chg
);

  localparam int CW = $clog2(max2(STABLE_CYCLES, BOT_RST_CYCLES) + 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
`ifdef MAP_SEL_BOT_RESET_EN
  localparam logic [CW-1:0] BOT_LAST = CW'(BOT_RST_CYCLES - 1);
`endif

  state_t        state_q, state_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          chg_q, chg_d;
  logic [1:0]    dreq;
  logic          vs_edge;
`ifdef MAP_SEL_BOT_RESET_EN
  logic          bot_q, bot_d;
`endif

  vs_edge_det #(
    .VS_ACTIVE (VS_ACTIVE)
  ) u_vs_edge_det (
    .clk       (clk),
    .reset_n   (reset_n),
    .vert_sync (vert_sync),
    .vs_edge   (vs_edge)
  );

  assign dreq = decode_req(map_req);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    chg_d   = 1'b0;
`ifdef MAP_SEL_BOT_RESET_EN
    bot_d   = bot_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (dreq != sel_q) begin
          cand_d  = dreq;
          cnt_d   = '0;
          state_d = ST_QUALIFY;
        end
      end
      ST_QUALIFY: begin
        if (dreq != cand_q)        state_d = ST_IDLE;
        else if (cnt_q == STB_LAST) state_d = ST_WAIT_VS;
        else                        cnt_d   = cnt_q + CW'(1);
      end
`ifdef MAP_SEL_BOT_RESET_EN
      ST_WAIT_VS: begin
        if (vs_edge) begin
          sel_d   = cand_q;
          bot_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BOT_RST;
        end
      end
      ST_BOT_RST: begin
        if (cnt_q == BOT_LAST) begin
          bot_d   = 1'b0;
          chg_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`else
      // cand never equals sel on entry, so equality here means the commit already happened.
      ST_WAIT_VS: begin
        if (sel_q == cand_q) begin
          chg_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (vs_edge) begin
          sel_d = cand_q;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cand_q  <= MAP_PART1;
      cnt_q   <= '0;
      sel_q   <= MAP_PART1;
      chg_q   <= 1'b0;
`ifdef MAP_SEL_BOT_RESET_EN
      bot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      chg_q   <= chg_d;
`ifdef MAP_SEL_BOT_RESET_EN
      bot_q   <= bot_d;
`endif
    end
  end

  assign map_sel   = sel_q;
  assign map_chg   = chg_q;
  assign switching = (state_q != ST_IDLE);
`ifdef MAP_SEL_BOT_RESET_EN
  assign bot_rst   = bot_q;
`else
  assign bot_rst   = 1'b0;
`endif

endmodule
